mix_columns: RTL and testbench



---
 rtl/aes_pkg.sv | 44 ++++
 rtl/mix_single_column.sv | 45 ++++
 rtl/mix_columns.sv | 60 ++++++
 tb/tb_mix_columns.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// ============================================================================
// Module      : aes_pkg
// Description : Shared AES types and GF(2^8) constant multipliers used by the
//               MixColumns / InvMixColumns datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_pkg;

   typedef logic [127:0] state_t;
   typedef logic [31:0]  col_t;
   typedef logic [7:0]   byte_t;

   // Low byte of the reduction polynomial x^8+x^4+x^3+x+1
   localparam byte_t AES_POLY = 8'h1B;

   function automatic byte_t xtime(input byte_t x);
      return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
   endfunction

   function automatic byte_t gmul3(input byte_t x);
      return xtime(x) ^ x;
   endfunction

   function automatic byte_t gmul9(input byte_t x);
      return xtime(xtime(xtime(x))) ^ x;
   endfunction

   function automatic byte_t gmul11(input byte_t x);
      return xtime(xtime(xtime(x))) ^ xtime(x) ^ x;
   endfunction

   function automatic byte_t gmul13(input byte_t x);
      return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ x;
   endfunction

   function automatic byte_t gmul14(input byte_t x);
      return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ xtime(x);
   endfunction

endpackage : aes_pkg

`default_nettype wire

// File: rtl/mix_single_column.sv
// ============================================================================
// Module      : mix_single_column
// Description : Combinational multiply of one 32-bit AES column by the
//               MixColumns (INVERSE=0) or InvMixColumns (INVERSE=1) matrix.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mix_single_column
   import aes_pkg::*;
#(
   parameter bit INVERSE = 1'b0
) (
   input  col_t col_in,
   output col_t col_out
);

   byte_t w_a [4];
   byte_t w_b [4];

   // Row 0 is the most significant byte of the column
   assign w_a[0] = col_in[31:24];
   assign w_a[1] = col_in[23:16];
   assign w_a[2] = col_in[15:8];
   assign w_a[3] = col_in[7:0];

   // The matrix is circulant: row r uses the row-0 coefficients rotated by r
   for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int c_k1 = (r + 1) % 4;
      localparam int c_k2 = (r + 2) % 4;
      localparam int c_k3 = (r + 3) % 4;
      if (INVERSE) begin : g_inv
         assign w_b[r] = gmul14(w_a[r])    ^ gmul11(w_a[c_k1])
                       ^ gmul13(w_a[c_k2]) ^ gmul9(w_a[c_k3]);
      end else begin : g_fwd
         assign w_b[r] = xtime(w_a[r]) ^ gmul3(w_a[c_k1])
                       ^ w_a[c_k2]     ^ w_a[c_k3];
      end
   end

   assign col_out = {w_b[0], w_b[1], w_b[2], w_b[3]};

endmodule : mix_single_column

`default_nettype wire

// File: rtl/mix_columns.sv
// ============================================================================
// Module      : mix_columns
// Description : Registered AES MixColumns / InvMixColumns stage, one state per
//               cycle with a single cycle of latency.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mix_columns
   import aes_pkg::*;
#(
   parameter bit INVERSE = 1'b0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   input  logic [127:0] in_data,
   output logic         out_valid,
   output logic [127:0] out_data
);

   col_t   w_col_in  [4];
   col_t   w_col_out [4];
   state_t w_mixed;
   state_t r_out_data;
   logic   r_out_valid;

   // Column 0 occupies the most significant word of the state
   for (genvar c = 0; c < 4; c++) begin : g_col
      assign w_col_in[c] = in_data[127-32*c -: 32];

      mix_single_column #(
         .INVERSE (INVERSE)
      ) u_col (
         .col_in  (w_col_in[c]),
         .col_out (w_col_out[c])
      );

      assign w_mixed[127-32*c -: 32] = w_col_out[c];
   end

   // Data only loads on a valid cycle so idle-cycle garbage never reaches out_data
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
      end else begin
         r_out_valid <= in_valid;
         if (in_valid) begin
            r_out_data <= w_mixed;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;

endmodule : mix_columns

`default_nettype wire

// File: tb/tb_mix_columns.sv
// ============================================================================
// Module      : tb_mix_columns
// Description : Scoreboard bench for forward and inverse mix_columns instances.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mix_columns;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         chain;
   logic         fwd_in_valid, fwd_out_valid;
   logic [127:0] fwd_in_data,  fwd_out_data;
   logic         tb_inv_valid, inv_in_valid, inv_out_valid;
   logic [127:0] tb_inv_data,  inv_in_data,  inv_out_data;

   int           total = 0;
   int           bad   = 0;
   logic [127:0] fwd_q [$];
   logic [127:0] inv_q [$];

   always #5 clk = ~clk;

   // In chain mode the inverse instance consumes the forward instance's output
   assign inv_in_valid = chain ? fwd_out_valid : tb_inv_valid;
   assign inv_in_data  = chain ? fwd_out_data  : tb_inv_data;

   mix_columns #(.INVERSE(1'b0)) dut_fwd (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (fwd_in_valid),
      .in_data   (fwd_in_data),
      .out_valid (fwd_out_valid),
      .out_data  (fwd_out_data)
   );

   mix_columns #(.INVERSE(1'b1)) dut_inv (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (inv_in_valid),
      .in_data   (inv_in_data),
      .out_valid (inv_out_valid),
      .out_data  (inv_out_data)
   );

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %032h expected %032h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard whenever an instance presents a result
   always @(negedge clk) begin
      if (fwd_out_valid && !chain) begin
         if (fwd_q.size() == 0) begin
            total++; bad++;
            $display("FAIL fwd_spurious: got out_valid=1 data=%032h expected no output", fwd_out_data);
         end else begin
            check("fwd_result", fwd_out_data, fwd_q.pop_front());
         end
      end
      if (inv_out_valid) begin
         if (inv_q.size() == 0) begin
            total++; bad++;
            $display("FAIL inv_spurious: got out_valid=1 data=%032h expected no output", inv_out_data);
         end else begin
            check("inv_result", inv_out_data, inv_q.pop_front());
         end
      end
   end

   task automatic send_fwd(input logic [127:0] d, input logic [127:0] e);
      @(posedge clk); #1;
      fwd_in_valid = 1'b1;
      fwd_in_data  = d;
      fwd_q.push_back(e);
   endtask

   task automatic idle_fwd();
      @(posedge clk); #1;
      fwd_in_valid = 1'b0;
      fwd_in_data  = {$urandom, $urandom, $urandom, $urandom};
   endtask

   task automatic send_inv(input logic [127:0] d, input logic [127:0] e);
      @(posedge clk); #1;
      tb_inv_valid = 1'b1;
      tb_inv_data  = d;
      inv_q.push_back(e);
   endtask

   task automatic idle_inv();
      @(posedge clk); #1;
      tb_inv_valid = 1'b0;
      tb_inv_data  = {$urandom, $urandom, $urandom, $urandom};
   endtask

   localparam logic [127:0] c_main_in  = 128'h87F24D976E4C90EC46E74AC3A68CD895;
   localparam logic [127:0] c_main_out = 128'hC2384D1874B136AD378E6BFA95432594;
   localparam logic [127:0] c_db_in    = {4{32'hDB135345}};
   localparam logic [127:0] c_db_out   = {4{32'h8E4DA1BC}};
   localparam logic [127:0] c_ones     = {4{32'h01010101}};
   localparam logic [127:0] c_mix_in   = 128'hF20A225CD4D4D4D52D26314CC6C6C6C6;
   localparam logic [127:0] c_mix_out  = 128'h9FDC589DD5D5D7D64D7EBDF8C6C6C6C6;
   localparam logic [127:0] c_fips_in  = 128'hD4BF5D30E0B452AEB84111F11E2798E5;
   localparam logic [127:0] c_fips_out = 128'h046681E5E0CB199A48F8D37A2806264C;

   initial begin
      logic [127:0] v;
      rst_n        = 1'b0;
      chain        = 1'b0;
      fwd_in_valid = 1'b1;
      fwd_in_data  = '1;
      tb_inv_valid = 1'b1;
      tb_inv_data  = '1;

      // Reset wins over in_valid
      repeat (3) begin
         @(negedge clk);
         check("rst_fwd_valid", {127'b0, fwd_out_valid}, 128'd0);
         check("rst_fwd_data",  fwd_out_data,             128'd0);
         check("rst_inv_valid", {127'b0, inv_out_valid}, 128'd0);
         check("rst_inv_data",  inv_out_data,             128'd0);
      end
      @(posedge clk); #1;
      rst_n        = 1'b1;
      fwd_in_valid = 1'b0;
      tb_inv_valid = 1'b0;

      send_fwd(c_main_in, c_main_out);
      idle_fwd();

      // Back-to-back stream, then idle with data held
      send_fwd(c_db_in,   c_db_out);
      send_fwd(c_ones,    c_ones);
      send_fwd(128'd0,    128'd0);
      send_fwd(c_fips_in, c_fips_out);
      send_fwd(c_mix_in,  c_mix_out);
      idle_fwd();
      @(negedge clk);
      repeat (2) begin
         @(negedge clk);
         check("hold_valid", {127'b0, fwd_out_valid}, 128'd0);
         check("hold_data",  fwd_out_data,             c_mix_out);
         @(posedge clk); #1;
         fwd_in_data = {$urandom, $urandom, $urandom, $urandom};
      end

      // Reset asserted while a new vector is being presented: that vector is lost
      send_fwd(c_main_in, c_main_out);
      @(posedge clk); #1;
      rst_n        = 1'b0;
      fwd_in_valid = 1'b1;
      fwd_in_data  = c_db_in;
      @(negedge clk);
      @(negedge clk);
      check("midrst_valid", {127'b0, fwd_out_valid}, 128'd0);
      check("midrst_data",  fwd_out_data,             128'd0);
      @(posedge clk); #1;
      rst_n        = 1'b1;
      fwd_in_valid = 1'b1;
      fwd_in_data  = c_fips_in;
      fwd_q.push_back(c_fips_out);
      idle_fwd();

      // Inverse directed vectors
      send_inv(c_main_out, c_main_in);
      send_inv(c_db_out,   c_db_in);
      send_inv(c_fips_out, c_fips_in);
      send_inv(c_ones,     c_ones);
      idle_inv();
      repeat (3) @(posedge clk);

      // Forward then inverse must round-trip random states
      #1 chain = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         v            = {$urandom, $urandom, $urandom, $urandom};
         fwd_in_valid = 1'b1;
         fwd_in_data  = v;
         inv_q.push_back(v);
      end
      idle_fwd();

      for (int i = 0; i < 20 && (fwd_q.size() != 0 || inv_q.size() != 0); i++) begin
         @(negedge clk);
      end
      total++;
      if (fwd_q.size() != 0 || inv_q.size() != 0) begin
         bad++;
         $display("FAIL drain: got fwd_pending=%0d inv_pending=%0d expected 0 and 0",
                  fwd_q.size(), inv_q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no completion expected finish before 200000");
      $fatal(1, "timeout");
   end

endmodule : tb_mix_columns

`default_nettype wire
